// File: rtl/booth_seq_pkg.sv
// Shared types and widths for the Booth multiplier operand sequencer.
package booth_seq_pkg;

    localparam int OP_W            = 4;
    localparam int PROD_W          = 8;
    localparam int MUL_LATENCY_DEF = 4;
    localparam int MUL_GAP_DEF     = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESULT,
        GAP
    } state_t;

    // Counter must reach the larger of the latency and gap counts.
    function automatic int cnt_width(input int lat, input int gap);
        int m;
        m = (lat > gap) ? lat : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_width(MUL_LATENCY_DEF, MUL_GAP_DEF);

endpackage

// File: rtl/operand_fifo.sv
// Synchronous FIFO of {a,b} operand pairs; extra pointer bit separates full from empty.
module operand_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW:0]                 rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][W-1:0]     mem_q, mem_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/booth_operand_sequencer.sv
// Feeds buffered operand pairs to the sequential Booth multiplier one at a time
// and returns {a,b,p} on a valid/ready result port.
module booth_operand_sequencer
    import booth_seq_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int MUL_GAP     = MUL_GAP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_a,
    output logic [OP_W-1:0]   out_b,
    output logic [PROD_W-1:0] out_p,
    output logic              busy
);

    localparam int            CW       = cnt_width(MUL_LATENCY, MUL_GAP);
    localparam logic [CW-1:0] LAT_C    = CW'(MUL_LATENCY);
    localparam logic [CW-1:0] GAP_C    = CW'(MUL_GAP);
    localparam logic [CW-1:0] GAP_LAST = CW'(MUL_GAP - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OP_W-1:0]     mul_a_q, mul_a_d;
    logic [OP_W-1:0]     mul_b_q, mul_b_d;
    logic [OP_W-1:0]     out_a_q, out_a_d;
    logic [OP_W-1:0]     out_b_q, out_b_d;
    logic [PROD_W-1:0]   out_p_q, out_p_d;
    logic                rdy_q;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*OP_W-1:0]   fifo_rdata;

    // rdy_q holds in_ready low through reset and for nothing longer.
    assign in_ready  = rdy_q && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    operand_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (2*OP_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_a, in_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        out_p_d = out_p_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    mul_a_d = fifo_rdata[2*OP_W-1:OP_W];
                    mul_b_d = fifo_rdata[OP_W-1:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == LAT_C) begin
                    out_a_d = mul_a_q;
                    out_b_d = mul_b_q;
                    out_p_d = mul_p;
                    cnt_d   = '0;
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESULT: begin
                // Gap time keeps accruing while the consumer stalls.
                if (cnt_q < GAP_C) cnt_d = cnt_q + 1'b1;
                if (out_ready) state_d = GAP;
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) state_d = IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
            out_p_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            out_p_q <= out_p_d;
            rdy_q   <= 1'b1;
        end
    end

    assign mul_start = (state_q == ISSUE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = (state_q == RESULT);
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_p     = out_p_q;
    assign busy      = !((state_q == IDLE) && fifo_empty);

endmodule
